// File: rtl/buzzer_pkg.sv
// buzzer_pkg: shared types and default timing constants for the washer
// front-panel beeper (buzzer_pattern_gen and its edge detector).
package buzzer_pkg;

  // Burst sequencer states. GAP is only reachable when BUZZER_REPEAT_EN is defined.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_e;

  // Which event launched the current burst.
  typedef enum logic {
    SRC_KEY    = 1'b0,
    SRC_FINISH = 1'b1
  } src_e;

  // Default parameter values for buzzer_pattern_gen.
  localparam int DEF_N_KEYS       = 4;
  localparam int DEF_ON_TICKS     = 2;
  localparam int DEF_OFF_TICKS    = 2;
  localparam int DEF_KEY_BEEPS    = 1;
  localparam int DEF_FINISH_BEEPS = 3;
  localparam int DEF_GAP_TICKS    = 8;
  localparam int DEF_CNT_W        = 4;

endpackage

// File: rtl/buzzer_edge_det.sv
// buzzer_edge_det: registers a W-bit input vector and flags bits that are
// high now but were low on the previous clk_buzzer edge.
// The history register is preloaded with the live input during reset, so a
// level already high when reset releases is never reported as a new edge.
// Ports:
//   clk_buzzer  in   clock
//   reset       in   synchronous, active-high reset (preloads history)
//   sig_i       in   W-bit input levels
//   rise_o      out  W-bit rising-edge flags (combinational, valid before each edge)
module buzzer_edge_det #(
  parameter int W = 1
) (
  input  logic         clk_buzzer,
  input  logic         reset,
  input  logic [W-1:0] sig_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] sig_q;

  always_ff @(posedge clk_buzzer) begin
    sig_q <= sig_i;
  end

  // While reset is high rise_o is still computed, but the sequencer is held
  // in reset, so those flags have no effect.
  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/buzzer_pattern_gen.sv
// buzzer_pattern_gen: turns panel key presses and the wash-cycle finish flag
// into timed beep bursts on one registered buzzer/LED output.
//   Key press   -> KEY_BEEPS beeps, low priority (restartable by another key).
//   Finish edge -> FINISH_BEEPS beeps, always wins, keys ignored meanwhile.
// A beep is ON_TICKS cycles high, beeps are separated by OFF_TICKS cycles low,
// and no low phase trails the last beep.
// Optional build macro BUZZER_REPEAT_EN: after a finish burst, wait GAP_TICKS
// cycles and replay while finish stays high; finish low or a key edge during
// the gap silences it.
// Ports:
//   clk_buzzer  in   buzzer time-base clock
//   reset       in   synchronous, active-high reset
//   key_evt     in   N_KEYS debounced key levels
//   finish      in   wash cycle finished (level)
//   buzzer_out  out  buzzer drive, registered
//   busy        out  high while a burst or repeat gap is in progress
//   src_finish  out  1 = finish burst, 0 = key burst (meaningful while busy)
module buzzer_pattern_gen
  import buzzer_pkg::*;
#(
  parameter int N_KEYS       = DEF_N_KEYS,
  parameter int ON_TICKS     = DEF_ON_TICKS,
  parameter int OFF_TICKS    = DEF_OFF_TICKS,
  parameter int KEY_BEEPS    = DEF_KEY_BEEPS,
  parameter int FINISH_BEEPS = DEF_FINISH_BEEPS,
  parameter int GAP_TICKS    = DEF_GAP_TICKS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic              clk_buzzer,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_evt,
  input  logic              finish,
  output logic              buzzer_out,
  output logic              busy,
  output logic              src_finish
);

`ifdef BUZZER_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_TICKS);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_TICKS);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0] KEY_LOAD = CNT_W'(KEY_BEEPS);
  localparam logic [CNT_W-1:0] FIN_LOAD = CNT_W'(FINISH_BEEPS);

  logic [N_KEYS-1:0] key_rise;
  logic              fin_rise;
  logic              key_edge;
  logic              fin_edge;

  state_e            state_q, state_d;
  src_e              src_q, src_d;
  logic [CNT_W-1:0]  phase_q, phase_d;   // cycles left in the current phase
  logic [CNT_W-1:0]  beeps_q, beeps_d;   // beeps left, including the current one
  logic              buzzer_q, buzzer_d;
  logic              busy_q, busy_d;

  buzzer_edge_det #(.W(N_KEYS)) u_key_edge (
    .clk_buzzer (clk_buzzer),
    .reset      (reset),
    .sig_i      (key_evt),
    .rise_o     (key_rise)
  );

  buzzer_edge_det #(.W(1)) u_fin_edge (
    .clk_buzzer (clk_buzzer),
    .reset      (reset),
    .sig_i      (finish),
    .rise_o     (fin_rise)
  );

  // Several keys rising together still count as a single event.
  assign key_edge = |key_rise;
  assign fin_edge = fin_rise;

  // State register.
  always_ff @(posedge clk_buzzer) begin
    if (reset) begin
      state_q  <= IDLE;
      src_q    <= SRC_KEY;
      phase_q  <= '0;
      beeps_q  <= '0;
      buzzer_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      phase_q  <= phase_d;
      beeps_q  <= beeps_d;
      buzzer_q <= buzzer_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic: timed sequencing first, then event overrides.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    phase_d = phase_q;
    beeps_d = beeps_q;

    case (state_q)
      ON: begin
        if (phase_q == CNT_ONE) begin
          beeps_d = beeps_q - CNT_ONE;
          if (beeps_q == CNT_ONE) begin
            if (REPEAT_EN && (src_q == SRC_FINISH) && finish) begin
              state_d = GAP;
              phase_d = GAP_LOAD;
            end else begin
              state_d = IDLE;
              phase_d = '0;
            end
          end else begin
            state_d = OFF;
            phase_d = OFF_LOAD;
          end
        end else begin
          phase_d = phase_q - CNT_ONE;
        end
      end
      OFF: begin
        if (phase_q == CNT_ONE) begin
          state_d = ON;
          phase_d = ON_LOAD;
        end else begin
          phase_d = phase_q - CNT_ONE;
        end
      end
      GAP: begin
        if (!finish) begin
          state_d = IDLE;
          phase_d = '0;
        end else if (phase_q == CNT_ONE) begin
          state_d = ON;
          phase_d = ON_LOAD;
          beeps_d = FIN_LOAD;
        end else begin
          phase_d = phase_q - CNT_ONE;
        end
      end
      default: begin
      end
    endcase

    // Finish always (re)starts; a key may only restart an idle or key burst.
    if (fin_edge) begin
      state_d = ON;
      src_d   = SRC_FINISH;
      phase_d = ON_LOAD;
      beeps_d = FIN_LOAD;
    end else if (key_edge) begin
      if (REPEAT_EN && (state_q == GAP)) begin
        // Silence-by-key: drop the repeat without sounding a key beep.
        state_d = IDLE;
        phase_d = '0;
        beeps_d = '0;
      end else if ((state_q == IDLE) || (src_q == SRC_KEY)) begin
        state_d = ON;
        src_d   = SRC_KEY;
        phase_d = ON_LOAD;
        beeps_d = KEY_LOAD;
      end
    end
  end

  // Output logic: decoded from the next state so outputs register in step with it.
  always_comb begin
    buzzer_d = (state_d == ON);
    busy_d   = (state_d != IDLE);
  end

  assign buzzer_out = buzzer_q;
  assign busy       = busy_q;
  assign src_finish = (src_q == SRC_FINISH);

endmodule
